// File: rtl/aes_round_ctrl_if.sv
// Valid/ready bundle between the payload source, the AES round controller and the framer.
// The master modport is the side that supplies plaintext and takes ciphertext.
interface aes_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  modport master (
    output in_valid, key_in, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, key_in, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one full round per clock with on-the-fly key expansion,
// one block in flight, valid/ready on both the plaintext and ciphertext sides.
module aes_round_ctrl #(
  parameter bit LOOPBACK_ACCEPT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus,
  output logic             busy,
  output logic [3:0]       round_cnt
);

  localparam int DATA_W = 128;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   state_reg;
  logic [DATA_W-1:0]   key_reg;
  logic [DATA_W-1:0]   next_key;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   round_out;
  logic [7:0]          rcon;
  logic                accept;
  logic                step;
  logic                drop;
  logic                in_ready_c;
  logic                out_valid_c;
  logic                busy_c;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TAB[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 2a0^3a1^a2^a3 rewritten as a0 ^ (a0^a1^a2^a3) ^ xtime(a0^a1), and rotations thereof.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, t;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    t  = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1),
            a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3),
            a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  // Byte r+4c sits at bit 127-8(r+4c); ShiftRows moves row r left by r columns.
  function automatic logic [DATA_W-1:0] sub_shift(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [DATA_W-1:0] mix_columns(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [DATA_W-1:0] expand_key(input logic [DATA_W-1:0] k,
                                                   input logic [7:0]        rc);
    logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = w0 ^ sub ^ {rc, 24'h0};
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    next_key  = expand_key(key_reg, rcon);
    shifted   = sub_shift(state_reg);
    round_out = ((round_cnt == 4'd10) ? shifted : mix_columns(shifted)) ^ next_key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    accept      = 1'b0;
    step        = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        busy_c = 1'b1;
        step   = 1'b1;
        if (round_cnt == 4'd10) state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = LOOPBACK_ACCEPT ? bus.out_ready : 1'b0;
        if (bus.out_ready) begin
          // Loopback lets the next block start on the handshake edge itself.
          if (LOOPBACK_ACCEPT && bus.in_valid) begin
            accept    = 1'b1;
            state_nxt = ROUND;
          end else begin
            drop      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      rcon      <= 8'h01;
      round_cnt <= 4'd0;
    end else if (accept) begin
      state_reg <= bus.data_in ^ bus.key_in;
      key_reg   <= bus.key_in;
      rcon      <= 8'h01;
      round_cnt <= 4'd1;
    end else if (step) begin
      state_reg <= round_out;
      key_reg   <= next_key;
      rcon      <= xtime(rcon);
      if (round_cnt != 4'd10) round_cnt <= round_cnt + 4'd1;
    end else if (drop) begin
      round_cnt <= 4'd0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.data_out  = state_reg;
  assign busy          = busy_c;

endmodule
